// File: rtl/slice_subtractor64.sv
// Slice-serial subtractor: D = A - B - Bin, SLICE bits per clock, borrow carried in a register.
// Optional macro SLICE_SUB_OVF_EN adds the registered signed-overflow output ovf.
module slice_subtractor64 #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             zero,
  output logic             lt_s
`ifdef SLICE_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_dwork;
  logic             r_borrow;
  logic [KW-1:0]    r_k;

  logic [SLICE-1:0] w_a_k;
  logic [SLICE-1:0] w_b_k;
  logic [SLICE:0]   w_diff;
  logic             w_n;
  logic             w_v;

  // One slice per cycle; the top bit of the widened difference is the borrow into the next slice.
  assign w_a_k  = r_a[int'(r_k) * SLICE +: SLICE];
  assign w_b_k  = r_b[int'(r_k) * SLICE +: SLICE];
  assign w_diff = {1'b0, w_a_k} - {1'b0, w_b_k} - {{SLICE{1'b0}}, r_borrow};

  assign w_n = r_dwork[WIDTH-1];
  assign w_v = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (r_dwork[WIDTH-1] != r_a[WIDTH-1]);

  // Control FSM, slice datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_dwork  <= {WIDTH{1'b0}};
      r_borrow <= 1'b0;
      r_k      <= {KW{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      D        <= {WIDTH{1'b0}};
      Bout     <= 1'b0;
      zero     <= 1'b0;
      lt_s     <= 1'b0;
`ifdef SLICE_SUB_OVF_EN
      ovf      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= A;
            r_b      <= B;
            r_borrow <= Bin;
            r_k      <= {KW{1'b0}};
            busy     <= 1'b1;
            r_state  <= S_RUN;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_RUN: begin
          r_dwork[int'(r_k) * SLICE +: SLICE] <= w_diff[SLICE-1:0];
          r_borrow <= w_diff[SLICE];
          if (r_k == K_LAST) begin
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_k     <= r_k + KW'(1);
          end
        end
        S_DONE: begin
          // Results are published only here, so they hold through any later RUN.
          done    <= 1'b1;
          D       <= r_dwork;
          Bout    <= r_borrow;
          zero    <= (r_dwork == {WIDTH{1'b0}});
          lt_s    <= w_n ^ w_v;
`ifdef SLICE_SUB_OVF_EN
          ovf     <= w_v;
`endif
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
